icache_direct: RTL
==================

# icache_direct

Direct-mapped, parametrised instruction cache that replaces the flat instruction ROM lookup in the fetch stage. It serves 32-bit instruction words to fetch combinationally on a hit. On a miss it stalls fetch and refills a whole line from a word-wide backing memory (the program ROM at 0xBFC00000 or a later memory system) using a valid-handshake refill engine.

## Interface
- `ADDRESS_WIDTH`, default 32: fetch and memory address width.
- `DATA_WIDTH`, default 32: instruction word width; must be 32.
- `SETS`, default 16: number of lines; power of two, ≥2.
- `WORDS_PER_LINE`, default 4: words per line; power of two, ≥2.
- `clk`, in, 1: single clock; everything is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `addr`, in, ADDRESS_WIDTH: fetch PC; bits [1:0] are ignored.
- `flush`, in, 1: invalidate all lines (fence.i).
- `dout`, out, DATA_WIDTH: instruction word; valid only when `hit`=1.
- `hit`, out, 1: combinational tag match and line valid.
- `stall`, out, 1: equals ~`hit`; fetch holds the PC while it is high.
- `mem_req`, out, 1: refill request is active.
- `mem_addr`, out, ADDRESS_WIDTH: word address being requested.
- `mem_valid`, in, 1: `mem_rdata` is valid for the current `mem_addr`.
- `mem_rdata`, in, DATA_WIDTH: refill word.

## Operation
- Address split:
  - OFF = log2(WORDS_PER_LINE) word-offset bits at [OFF+1:2].
  - IDX = log2(SETS) index bits above OFF.
  - Tag is the remaining upper bits.
- Storage:
  - Data array is SETS×WORDS_PER_LINE words.
  - Tag array and valid bit array are SETS entries each.
  - Reads are combinational (async); writes are clocked.
- `hit` = valid[idx] && tag[idx]==addr tag. `dout` = data[idx][off].
- Refill FSM states:
  - IDLE to REFILL when `hit`=0, `flush`=0 and `rst`=0. On entry, latch line base = addr with offset and byte bits cleared, and set word counter `cnt`=0.
  - REFILL: `mem_req`=1 and `mem_addr` = base + 4·cnt. Each cycle with `mem_valid`=1, write `mem_rdata` into data[base idx][cnt] and increment `cnt`.
  - On the `mem_valid` for cnt = WORDS_PER_LINE−1: write the tag, set valid, go to IDLE.
  - Cycles with `mem_valid`=0 hold `cnt` and `mem_addr` (backing memory may insert any number of wait cycles).
- The valid bit is cleared for the refilling index on REFILL entry. A partially written line therefore never hits.
- `addr` may change during REFILL; the refill completes to the latched base regardless. If the new addr misses, a fresh refill starts from IDLE afterwards.
- `flush`:
  - Clears all valid bits in one cycle.
  - In REFILL, aborts: return to IDLE, no tag/valid write, `mem_req` drops the next cycle.
  - Flush has priority over the final refill write in the same cycle.
- Arithmetic: `cnt` is OFF bits wide and wraps only via the state exit. `mem_addr` addition is ADDRESS_WIDTH modulo.

## Timing
- Reset values:
  - state IDLE, all valid bits 0, `cnt`=0.
  - `mem_req`=0, `mem_addr`=0.
  - `hit`=0 and `stall`=1 (all lines invalid); `dout` is don't-care.
- Hit latency: 0 cycles, combinational from `addr`.
- Miss penalty with zero-wait memory:
  - Cycle 0: miss detected.
  - Cycles 1..WORDS_PER_LINE: refill, `mem_req`=1.
  - Cycle WORDS_PER_LINE+1: hit.
  - Total WORDS_PER_LINE+1 stall cycles.
- `mem_req` and `mem_addr` are registered outputs. `mem_valid` is sampled at the rising edge where `mem_req`=1; `mem_valid` while `mem_req`=0 is ignored.
- `rst` mid-refill: the next edge returns to reset values; the line is not validated.

## Configuration
- `ICACHE_STATS_EN` defined:
  - Adds outputs `hit_count` and `miss_count` (32 bits each), reset to 0.
  - `hit_count` increments on each cycle with `hit`=1.
  - `miss_count` increments on each IDLE→REFILL transition.
  - Both saturate at 0xFFFFFFFF.
  - Unaffected by `flush`.
- Not defined: these ports and counters do not exist.

## Structure
- `icache_pkg`:
  - State enum (IDLE, REFILL).
  - `RESET_VECTOR` = 32'hBFC00000.
  - Functions deriving OFF, IDX and tag widths from the parameters.
- Sub-module `icache_refill`: holds the FSM, `cnt`, the base latch, `mem_req` and `mem_addr`. It drives write enables and the write index/offset into the top level, which owns the arrays.

## Test plan
- Reset, then addr=0xBFC00000, with memory returning 0x00000013, 0x00100093, 0x00200113, 0x00300193 at zero wait:
  - Expect `mem_addr` 0xBFC00000, …04, …08, …0C.
  - Expect `hit` after 5 stall cycles and `dout`=0x00000013.
- Addr=0xBFC00008 after that refill → `hit`=1 immediately, `dout`=0x00200113, `mem_req`=0.
- Default params, addr=0xBFC00100 (same index 0, different tag):
  - Expect a miss and refill.
  - Returning to 0xBFC00000 then misses again (eviction).
- Memory with 2 wait cycles per word → `mem_addr` held across waits, miss penalty 13 cycles, data correct.
- `flush` asserted on the 2nd refill word:
  - `mem_req` drops the next cycle and the line stays invalid.
  - A following access refills from word 0.
- With `ICACHE_STATS_EN`: reset, 1 miss, then 3 hit cycles → `miss_count`=1, `hit_count`=3.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared types and helpers for the direct-mapped instruction cache.
//   state_e       refill engine states (IDLE, REFILL)
//   RESET_VECTOR  boot address of the program ROM
//   off_bits/idx_bits/tag_bits  derive the address-split widths from the
//   cache parameters.
package icache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  function automatic int unsigned off_bits(input int unsigned words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned address_width,
                                           input int unsigned sets,
                                           input int unsigned words_per_line);
    return address_width - $clog2(sets) - $clog2(words_per_line) - 2;
  endfunction

endpackage

// File: rtl/icache_refill.sv
// icache_refill: line refill engine for icache_direct.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   hit, flush      lookup result and invalidate request from the top level
//   line_addr       fetch address with byte and word-offset bits removed
//   mem_req         registered: refill in progress
//   mem_addr        registered: word address currently requested
//   mem_valid       backing memory returns the word for mem_addr
//   start           pulse on the IDLE->REFILL transition
//   data_we         write mem_rdata into data[fill_line idx][wr_off]
//   wr_off          word offset being written
//   fill_done       last word accepted: write tag and set valid
//   fill_line       latched line address (index + tag) of the refill
module icache_refill
  import icache_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  localparam int unsigned OFF    = off_bits(WORDS_PER_LINE),
  localparam int unsigned LINE_W = ADDRESS_WIDTH - OFF - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hit,
  input  logic                     flush,
  input  logic [LINE_W-1:0]        line_addr,
  output logic                     mem_req,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic                     mem_valid,
  output logic                     start,
  output logic                     data_we,
  output logic [OFF-1:0]           wr_off,
  output logic                     fill_done,
  output logic [LINE_W-1:0]        fill_line
);

  state_e                   state_q, state_d;
  logic [OFF-1:0]           cnt_q, cnt_d;
  logic [LINE_W-1:0]        base_q, base_d;
  logic                     mem_req_q, mem_req_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    mem_req_d = mem_req_q;
    start     = 1'b0;
    data_we   = 1'b0;
    fill_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit && !flush) begin
          state_d   = REFILL;
          base_d    = line_addr;
          cnt_d     = '0;
          mem_req_d = 1'b1;
          start     = 1'b1;
        end
      end
      REFILL: begin
        // Flush wins over a word arriving in the same cycle, including the last.
        if (flush) begin
          state_d   = IDLE;
          cnt_d     = '0;
          mem_req_d = 1'b0;
        end else if (mem_valid) begin
          data_we = 1'b1;
          if (&cnt_q) begin
            fill_done = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
            mem_req_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Line base concatenated with the word counter is base + 4*cnt without a
    // carry into the index/tag, since cnt never wraps inside a refill.
    mem_addr_d = {base_d, cnt_d, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign wr_off    = cnt_q;
  assign fill_line = base_q;

endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped instruction cache in front of a word-wide
// backing memory. Hits are served combinationally; misses stall fetch while
// icache_refill fetches the whole line.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   addr                fetch PC (bits [1:0] ignored)
//   flush               invalidate every line (fence.i), aborts a refill
//   dout, hit, stall    instruction word, tag match + valid, ~hit
//   mem_req, mem_addr   registered refill request / word address
//   mem_valid, mem_rdata refill word handshake from the backing memory
//   hit_count, miss_count  saturating statistics, only when the macro
//                       ICACHE_STATS_EN is defined
module icache_direct
  import icache_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SETS           = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic                     flush,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     hit,
  output logic                     stall,
  output logic                     mem_req,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic                     mem_valid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
`endif
);

  localparam int unsigned OFF    = off_bits(WORDS_PER_LINE);
  localparam int unsigned IDX    = idx_bits(SETS);
  localparam int unsigned TAG    = tag_bits(ADDRESS_WIDTH, SETS, WORDS_PER_LINE);
  localparam int unsigned LINE_W = ADDRESS_WIDTH - OFF - 2;

  logic [DATA_WIDTH-1:0] data_ram [SETS][WORDS_PER_LINE];
  logic [TAG-1:0]        tag_ram  [SETS];
  logic [SETS-1:0]       valid_q, valid_d;

  logic [OFF-1:0]    rd_off;
  logic [IDX-1:0]    rd_idx;
  logic [TAG-1:0]    rd_tag;
  logic [LINE_W-1:0] fill_line;
  logic [IDX-1:0]    fill_idx;
  logic [TAG-1:0]    fill_tag;
  logic [OFF-1:0]    wr_off;
  logic              start;
  logic              data_we;
  logic              fill_done;
  logic              unused_addr_lsbs;

  assign rd_off   = addr[2 +: OFF];
  assign rd_idx   = addr[OFF+2 +: IDX];
  assign rd_tag   = addr[ADDRESS_WIDTH-1 -: TAG];
  assign fill_idx = fill_line[IDX-1:0];
  assign fill_tag = fill_line[LINE_W-1 -: TAG];
  assign unused_addr_lsbs = ^addr[1:0];

  assign hit   = valid_q[rd_idx] && (tag_ram[rd_idx] == rd_tag);
  assign stall = ~hit;
  assign dout  = data_ram[rd_idx][rd_off];

  icache_refill #(
    .ADDRESS_WIDTH  (ADDRESS_WIDTH),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_refill (
    .clk       (clk),
    .rst       (rst),
    .hit       (hit),
    .flush     (flush),
    .line_addr (addr[ADDRESS_WIDTH-1:OFF+2]),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .start     (start),
    .data_we   (data_we),
    .wr_off    (wr_off),
    .fill_done (fill_done),
    .fill_line (fill_line)
  );

  // The refilling line is invalidated on entry so a partial line never hits.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      if (start)     valid_d[rd_idx]   = 1'b0;
      if (fill_done) valid_d[fill_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && data_we)   data_ram[fill_idx][wr_off] <= mem_rdata;
    if (!rst && fill_done) tag_ram[fill_idx]          <= fill_tag;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit && (hit_count_q != '1))    hit_count_d  = hit_count_q + 32'd1;
    if (start && (miss_count_q != '1)) miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
